// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jam_pkg
//  Brief   : Shared sizes, FSM encoding and helpers for the JAM cost loader.
//  Revision: 1.0
// ============================================================================
package jam_pkg;

    localparam int N_W     = 8;
    localparam int COST_W  = 7;
    localparam int MIN_W   = 10;
    localparam int CYC_W   = 20;
    localparam int MATCH_W = 4;
    localparam int IDX_W   = $clog2(N_W);
    localparam int ADDR_W  = 2 * IDX_W;
    localparam int DEPTH   = N_W * N_W;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Run-cycle counter sticks at all-ones rather than wrapping.
    function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jam_cost_ram.sv
`default_nettype none
// ============================================================================
//  Module  : jam_cost_ram
//  Brief   : DEPTH x COST_W register file, one sync write, one async read.
//  Revision: 1.0
// ============================================================================
module jam_cost_ram
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COST_W-1:0] rd_data
);

    logic [DEPTH-1:0][COST_W-1:0] table_w;

    // Contents are intentionally not reset; the consumer is held off until a full load.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [COST_W-1:0] entry_q;
        logic [COST_W-1:0] entry_d;

        always_comb begin
            entry_d = entry_q;
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                entry_d = wr_data;
            end
        end

        always_ff @(posedge CLK) begin
            entry_q <= entry_d;
        end

        assign table_w[i] = entry_q;
    end

    assign rd_data = table_w[rd_addr];

endmodule
`default_nettype wire

// File: rtl/jam_cost_loader.sv
`default_nettype none
// ============================================================================
//  Module  : jam_cost_loader
//  Brief   : Streams a cost table in, runs JAM once, captures its result.
//  Revision: 1.0
// ============================================================================
module jam_cost_loader
    import jam_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic [COST_W-1:0]  in_data,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   W,
    input  logic [IDX_W-1:0]   J,
    output logic [COST_W-1:0]  Cost,
    output logic               jam_rst,
    input  logic               jam_valid,
    input  logic [MIN_W-1:0]   jam_min_cost,
    input  logic [MATCH_W-1:0] jam_match_count,
    output logic               res_valid,
    output logic [MIN_W-1:0]   res_min_cost,
    output logic [MATCH_W-1:0] res_match_count,
    output logic [CYC_W-1:0]   res_cycles,
    input  logic               res_ack
);

    state_t               state_q,           state_d;
    logic [ADDR_W-1:0]    wr_ptr_q,          wr_ptr_d;
    logic                 jam_rst_q,         jam_rst_d;
    logic [CYC_W-1:0]     cyc_q,             cyc_d;
    logic                 res_valid_q,       res_valid_d;
    logic [MIN_W-1:0]     res_min_cost_q,    res_min_cost_d;
    logic [MATCH_W-1:0]   res_match_count_q, res_match_count_d;
    logic [CYC_W-1:0]     res_cycles_q,      res_cycles_d;
    logic                 wr_en;

    jam_cost_ram u_ram (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_addr ({W, J}),
        .rd_data (Cost)
    );

    always_comb begin
        state_d           = state_q;
        wr_ptr_d          = wr_ptr_q;
        jam_rst_d         = jam_rst_q;
        cyc_d             = cyc_q;
        res_valid_d       = res_valid_q;
        res_min_cost_d    = res_min_cost_q;
        res_match_count_d = res_match_count_q;
        res_cycles_d      = res_cycles_q;
        in_ready          = 1'b0;
        wr_en             = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        wr_ptr_d  = '0;
                        jam_rst_d = 1'b0;
                        cyc_d     = '0;
                        state_d   = ST_RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (jam_valid) begin
                    res_min_cost_d    = jam_min_cost;
                    res_match_count_d = jam_match_count;
                    res_cycles_d      = cyc_q;
                    res_valid_d       = 1'b1;
                    jam_rst_d         = 1'b1;
                    state_d           = ST_DONE;
                end else begin
                    cyc_d = cyc_sat_inc(cyc_q);
                end
            end
            ST_DONE: begin
                // Result stays frozen until the consumer acknowledges it.
                if (res_ack && res_valid_q) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                jam_rst_d   = 1'b1;
                res_valid_d = 1'b0;
                state_d     = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q           <= ST_LOAD;
            wr_ptr_q          <= '0;
            jam_rst_q         <= 1'b1;
            cyc_q             <= '0;
            res_valid_q       <= 1'b0;
            res_min_cost_q    <= '0;
            res_match_count_q <= '0;
            res_cycles_q      <= '0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            jam_rst_q         <= jam_rst_d;
            cyc_q             <= cyc_d;
            res_valid_q       <= res_valid_d;
            res_min_cost_q    <= res_min_cost_d;
            res_match_count_q <= res_match_count_d;
            res_cycles_q      <= res_cycles_d;
        end
    end

    assign jam_rst         = jam_rst_q;
    assign res_valid       = res_valid_q;
    assign res_min_cost    = res_min_cost_q;
    assign res_match_count = res_match_count_q;
    assign res_cycles      = res_cycles_q;

endmodule
`default_nettype wire
